// File: rtl/multi_tick_gen_pkg.sv
// Shared constants for the multi-channel tick generator: default widths and divisors,
// channel limit and common divisors for a 100 MHz clock.
package multi_tick_gen_pkg;

  localparam int unsigned CNT_W_DEFAULT   = 31;
  localparam int unsigned RST_DIV_DEFAULT = 100_000_000;
  localparam int unsigned MAX_CH          = 8;
  localparam int unsigned CH_IDX_W        = 3;

  // A divisor of N gives a tick period of N+1 cycles.
  localparam int unsigned DIV_1S_100MHZ      = 100_000_000 - 1;
  localparam int unsigned DIV_25MS_100MHZ    = 2_500_000 - 1;
  localparam int unsigned DIV_REFRESH_100MHZ = (1 << 20) - 1;  // ~95.4 Hz

  function automatic int unsigned div_for_period(input int unsigned period);
    return (period == 0) ? 0 : period - 1;
  endfunction

endpackage

// File: rtl/multi_tick_gen_tick_chan.sv
// One tick channel: divisor register, wrapping counter, registered one-cycle tick and,
// when MULTI_TICK_GEN_SQ_EN is defined, a square wave toggling on every tick.
module tick_chan
  import multi_tick_gen_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEFAULT,
  parameter int unsigned RST_DIV = RST_DIV_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             we_i,
  input  logic [CNT_W-1:0] div_i,
  output logic             tick_o
`ifdef MULTI_TICK_GEN_SQ_EN
  ,
  output logic             sq_o
`endif
);

  localparam logic [CNT_W-1:0] RstDivVal = CNT_W'(RST_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;
  logic             wrap;

  always_comb begin
    // >= so a divisor shrunk below the running count wraps at once instead of overflowing.
    wrap   = en_i && (cnt_q >= div_q);
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    div_d  = div_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (wrap) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (we_i) begin
      div_d = div_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      div_q  <= RstDivVal;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

`ifdef MULTI_TICK_GEN_SQ_EN
  logic sq_q, sq_d;

  always_comb begin
    sq_d = sq_q;
    if (clr_i) begin
      sq_d = 1'b0;
    end else if (wrap) begin
      sq_d = ~sq_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sq_q <= 1'b0;
    end else begin
      sq_q <= sq_d;
    end
  end

  assign sq_o = sq_q;
`endif

endmodule

// File: rtl/multi_tick_gen.sv
// Bank of NUM_CH independent programmable tick generators sharing one divisor write port.
// Optional square-wave outputs are built when MULTI_TICK_GEN_SQ_EN is defined.
module multi_tick_gen
  import multi_tick_gen_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CNT_W   = CNT_W_DEFAULT,
  parameter int unsigned RST_DIV = RST_DIV_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   en,
  input  logic                sync_clr,
  input  logic                cfg_we,
  input  logic [CH_IDX_W-1:0] cfg_ch,
  input  logic [CNT_W-1:0]    cfg_div,
  output logic [NUM_CH-1:0]   tick
`ifdef MULTI_TICK_GEN_SQ_EN
  ,
  output logic [NUM_CH-1:0]   sq
`endif
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    localparam logic [CH_IDX_W-1:0] ChIdx = CH_IDX_W'(g);

    // Indices at or above NUM_CH match no channel, so such writes fall away.
    logic we;
    assign we = cfg_we && (cfg_ch == ChIdx);

    tick_chan #(
      .CNT_W  (CNT_W),
      .RST_DIV(RST_DIV)
    ) u_chan (
      .clk_i (clk),
      .rst_i (rst),
      .en_i  (en[g]),
      .clr_i (sync_clr),
      .we_i  (we),
      .div_i (cfg_div),
      .tick_o(tick[g])
`ifdef MULTI_TICK_GEN_SQ_EN
      ,
      .sq_o  (sq[g])
`endif
    );
  end

endmodule

// File: tb/tb_multi_tick_gen.sv
// Directed and randomised checks of multi_tick_gen against a cycle-level behavioural model.
module tb_multi_tick_gen;

  localparam int NCh   = 4;
  localparam int CntW  = 16;
  localparam int RDiv  = 20;

  logic            clk;
  logic            rst;
  logic [NCh-1:0]  en;
  logic            sync_clr;
  logic            cfg_we;
  logic [2:0]      cfg_ch;
  logic [CntW-1:0] cfg_div;
  logic [NCh-1:0]  tick;
`ifdef MULTI_TICK_GEN_SQ_EN
  logic [NCh-1:0]  sq;
`endif

  multi_tick_gen #(
    .NUM_CH (NCh),
    .CNT_W  (CntW),
    .RST_DIV(RDiv)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .sync_clr(sync_clr),
    .cfg_we  (cfg_we),
    .cfg_ch  (cfg_ch),
    .cfg_div (cfg_div),
    .tick    (tick)
`ifdef MULTI_TICK_GEN_SQ_EN
    ,
    .sq      (sq)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // Reference model: position within the period and divisor per channel.
  int unsigned    m_cnt [NCh];
  int unsigned    m_div [NCh];
  logic [NCh-1:0] m_tick;
  logic [NCh-1:0] m_sq;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCh; c++) begin
      m_cnt[c] = 0;
      m_div[c] = RDiv;
    end
    m_tick = '0;
    m_sq   = '0;
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
      return;
    end
    for (int c = 0; c < NCh; c++) begin
      if (sync_clr) begin
        m_cnt[c]  = 0;
        m_tick[c] = 1'b0;
        m_sq[c]   = 1'b0;
      end else if (en[c]) begin
        if (m_cnt[c] >= m_div[c]) begin
          m_cnt[c]  = 0;
          m_tick[c] = 1'b1;
          m_sq[c]   = ~m_sq[c];
        end else begin
          m_cnt[c]++;
          m_tick[c] = 1'b0;
        end
      end else begin
        m_tick[c] = 1'b0;
      end
      if (cfg_we && int'(cfg_ch) == c) m_div[c] = int'(cfg_div);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("tick", 32'(tick), 32'(m_tick));
`ifdef MULTI_TICK_GEN_SQ_EN
    check("sq", 32'(sq), 32'(m_sq));
`endif
  endtask

  task automatic write_div(input int ch, input int val);
    cfg_we  = 1'b1;
    cfg_ch  = 3'(ch);
    cfg_div = CntW'(val);
    step();
    cfg_we  = 1'b0;
  endtask

  task automatic clear();
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
  endtask

  task automatic steps_to_tick(input int c, input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick[c] && n < limit);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt_t[NCh];
    int first_t[NCh];
    int exp_cnt[NCh]   = '{10, 40, 4, 20};
    int exp_first[NCh] = '{4, 6, 4, 2};

    rst = 1'b0; en = '0; sync_clr = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;
    #1 rst = 1'b1;
    #1;
    model_reset();
    check("reset_tick", 32'(tick), 32'd0);
`ifdef MULTI_TICK_GEN_SQ_EN
    check("reset_sq", 32'(sq), 32'd0);
`endif
    step();
    step();
    rst = 1'b0;
    en  = '1;
    steps_to_tick(0, 40, n);
    check("first_tick_after_reset", 32'(n), 32'(RDiv + 1));

    // Divisors 3,0,9,1 -> periods 4,1,10,2 over 40 aligned cycles.
    write_div(0, 3);
    write_div(1, 0);
    write_div(2, 9);
    write_div(3, 1);
    clear();
    check("clr_tick", 32'(tick), 32'd0);
    cnt_t = '{0, 0, 0, 0};
    for (int i = 0; i < 40; i++) begin
      step();
      for (int c = 0; c < NCh; c++) if (tick[c]) cnt_t[c]++;
    end
    for (int c = 0; c < NCh; c++) check($sformatf("tick_count_ch%0d", c), 32'(cnt_t[c]),
                                        32'(exp_cnt[c]));

    // Enable gap of 5 cycles at cnt=4 on ch2 (div 9): tick at 6 + 5 edges.
    clear();
    repeat (4) step();
    en[2] = 1'b0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      n++;
      if (tick[2]) check("tick_while_disabled", 32'(tick[2]), 32'd0);
    end
    en[2] = 1'b1;
    while (!tick[2] && n < 40) begin
      step();
      n++;
    end
    check("en_gap_delay", 32'(n), 32'd11);

    // Shrink divisor below running count: tick on the next edge, then period 4.
    clear();
    repeat (7) step();
    write_div(2, 3);
    step();
    check("shrink_tick_next_edge", 32'(tick[2]), 32'd1);
    steps_to_tick(2, 20, n);
    check("shrink_then_period", 32'(n), 32'd4);

    // Coincident clear and write to ch1.
    cfg_we = 1'b1; cfg_ch = 3'd1; cfg_div = CntW'(5); sync_clr = 1'b1;
    step();
    cfg_we = 1'b0; sync_clr = 1'b0;
    check("clr_we_tick", 32'(tick), 32'd0);
    first_t = '{0, 0, 0, 0};
    for (int i = 1; i <= 12; i++) begin
      step();
      for (int c = 0; c < NCh; c++) if (tick[c] && first_t[c] == 0) first_t[c] = i;
    end
    for (int c = 0; c < NCh; c++) check($sformatf("first_after_clr_ch%0d", c),
                                        32'(first_t[c]), 32'(exp_first[c]));

    // Out-of-range channel write must not touch any divisor; div 2 gives sq period 6.
    for (int c = 0; c < NCh; c++) write_div(c, 2);
    write_div(5, 0);
    clear();
    cnt_t = '{0, 0, 0, 0};
    for (int i = 0; i < 12; i++) begin
      step();
      for (int c = 0; c < NCh; c++) if (tick[c]) cnt_t[c]++;
    end
    check("oob_write_ch1_count", 32'(cnt_t[1]), 32'd4);
    check("oob_write_ch0_count", 32'(cnt_t[0]), 32'd4);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      en       = NCh'($urandom);
      sync_clr = ($urandom_range(0, 15) == 0);
      cfg_we   = ($urandom_range(0, 3) == 0);
      cfg_ch   = 3'($urandom_range(0, 7));
      cfg_div  = CntW'($urandom_range(0, 12));
      step();
    end
    en = '1; sync_clr = 1'b0; cfg_we = 1'b0;

    // Asynchronous reset while a tick is high.
    write_div(1, 0);
    step();
    check("pre_rst_tick1", 32'(tick[1]), 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_tick", 32'(tick), 32'd0);
`ifdef MULTI_TICK_GEN_SQ_EN
    check("async_rst_sq", 32'(sq), 32'd0);
`endif
    model_reset();
    step();
    rst = 1'b0;
    steps_to_tick(1, 40, n);
    check("first_tick_after_midrun_reset", 32'(n), 32'(RDiv + 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_tick_gen.md
MULTI_TICK_GEN -- requirements
Module: multi_tick_gen

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent tick channels, legal range 1..8.
REQ-002 Parameter CNT_W, default 31: width of each channel counter and divisor.
REQ-003 Parameter RST_DIV, default 100000000: divisor loaded into every channel at reset.
REQ-004 Port clk  input  1: single clock; all state on rising edge.
REQ-005 Port rst  input  1: asynchronous, active-high reset.
REQ-006 Port en  input  NUM_CH: per-channel count enable.
REQ-007 Port sync_clr  input  1: synchronous clear of all channel counters.
REQ-008 Port cfg_we  input  1: divisor write strobe, one cycle.
REQ-009 Port cfg_ch  input  3: channel index for the write.
REQ-010 Port cfg_div  input  CNT_W: new divisor value.
REQ-011 Port tick  output  NUM_CH: per-channel one-cycle pulse.
REQ-012 Port sq  output  NUM_CH: per-channel square wave; present only with the macro in REQ-029.

Function
REQ-013 Each channel SHALL hold a divisor register div[i] and a counter cnt[i], both CNT_W wide, unsigned.
REQ-014 A channel with en[i]=1 SHALL increment cnt[i] each cycle and wrap it to 0 on the edge where cnt[i]==div[i].
REQ-015 A channel SHALL register tick[i]=1 on the wrap edge, so tick[i] is high for exactly one cycle and its period is div[i]+1 cycles.
REQ-016 With div[i]=0 and en[i]=1, tick[i] SHALL be held high continuously.
REQ-017 With en[i]=0, cnt[i] SHALL hold its value and tick[i] SHALL be 0 on the next cycle.
REQ-018 With sync_clr=1, all cnt[i] SHALL be set to 0 and all tick[i] to 0 on the next cycle, regardless of en.
REQ-019 With cfg_we=1 and cfg_ch<NUM_CH, div[cfg_ch] SHALL take cfg_div on that edge; cnt is not reset.
REQ-020 A write with cfg_ch>=NUM_CH SHALL be ignored with no state change.
REQ-021 If cnt[i]>=div[i] after a divisor write, the channel SHALL wrap and tick on the next enabled edge (no 2^CNT_W overflow wait).
REQ-022 When cfg_we and sync_clr coincide, both SHALL take effect: the new divisor is stored and the counters are cleared.
REQ-023 A wrap edge coinciding with a write to the same channel SHALL use the old divisor for that edge's compare.
REQ-024 Channels SHALL be fully independent; no channel's timing depends on another's.

Reset
REQ-025 While rst=1: every cnt[i]=0, div[i]=RST_DIV (truncated to CNT_W), tick=0, sq=0.
REQ-026 After rst falls, the first tick on an enabled channel SHALL appear RST_DIV+1 edges later.
REQ-027 Reset asserted mid-count SHALL abandon the count immediately, with no pending tick.

Configuration
REQ-028 Macro MULTI_TICK_GEN_SQ_EN SHALL gate the sq port and its logic.
REQ-029 With MULTI_TICK_GEN_SQ_EN defined, sq[i] SHALL toggle on every tick[i] assertion edge (period 2*(div[i]+1)) and SHALL be cleared by sync_clr.
REQ-030 Without MULTI_TICK_GEN_SQ_EN, the sq port and its flops SHALL be absent; all other behaviour is identical.

Structure
REQ-031 Package multi_tick_gen_pkg SHALL hold the CNT_W default, the RST_DIV default, MAX_CH=8 and the common rate constants (1 s at 100 MHz, 25 ms, ~95 Hz display refresh).
REQ-032 One sub-module, tick_chan, SHALL implement a single channel (counter, divisor, tick, optional sq) and be instantiated NUM_CH times via generate.

Verification
REQ-033 NUM_CH=4, divisors written to 3, 0, 9, 1, all en=1 -> tick periods 4, 1 (constant high), 10 and 2 cycles.
REQ-034 div=9, en dropped for 5 cycles at cnt=4 -> the next tick is delayed exactly 5 cycles; no tick while en=0.
REQ-035 cnt=7 with div=9, write div=3 -> tick on the next edge, then period 4.
REQ-036 sync_clr pulse with cfg_we(ch1, div=5) in the same cycle -> all ticks 0 the next cycle, ch1 period 6 from cnt=0, other channels restart aligned.
REQ-037 rst asserted asynchronously mid-period -> tick=0 and sq=0 without a clock edge; first tick RST_DIV+1 edges after release (use RST_DIV=20 in sim).
REQ-038 With MULTI_TICK_GEN_SQ_EN, div=2 -> sq period 6 cycles, 50% duty; a write with cfg_ch=5 on a 4-channel build -> no divisor changes.
